vector_store_sequencer: RTL and testbench
=========================================

VECTOR_STORE_SEQUENCER -- requirements
Module: vector_store_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48, meaning width of the packed store word.
REQ-002 SHALL have parameter LANE_WIDTH, default 8, meaning width of one lane and of the memory data port.
REQ-003 SHALL have parameter LANES, default 6, meaning lanes per word; DATA_WIDTH = LANES*LANE_WIDTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-005 SHALL have a single clock: clk  in  1  clock, all state updates on the rising edge.
REQ-006 SHALL have reset: rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have port start  in  1  store request valid, sampled only in IDLE.
REQ-008 SHALL have port writeScalar  in  1  1 = scalar store (lane 0 only), 0 = vector store.
REQ-009 SHALL have port laneMask  in  LANES  per-lane write enable for vector stores; bit i = lane i.
REQ-010 SHALL have port baseAddr  in  ADDR_WIDTH  byte address of lane 0.
REQ-011 SHALL have port dataToWrite  in  DATA_WIDTH  packed store data; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH].
REQ-012 SHALL have port memReady  in  1  memory accepts the current beat this cycle.
REQ-013 SHALL have port memWe  out  1  write beat valid.
REQ-014 SHALL have port memAddr  out  ADDR_WIDTH  beat address.
REQ-015 SHALL have port memData  out  LANE_WIDTH  beat data.
REQ-016 SHALL have port stall  out  1  pipeline hold request.
REQ-017 SHALL have port done  out  1  one-cycle store-complete pulse.

Function
REQ-018 SHALL implement states IDLE, WRITE, DONE, registered.
REQ-019 In IDLE with start=1, SHALL capture baseAddr, dataToWrite, and the effective mask on that edge; effective mask = 6'b000001 when writeScalar=1, else laneMask.
REQ-020 From IDLE with start=1, SHALL go to WRITE if the effective mask is non-zero, else to DONE with no beats issued.
REQ-021 In IDLE with start=0, SHALL remain in IDLE.
REQ-022 In WRITE, SHALL drive memWe=1, memData=captured lane k and memAddr=(captured base + k) mod 2^ADDR_WIDTH, where k = lowest-index set bit of the remaining mask.
REQ-023 Masked-off lanes SHALL consume no cycles: the next beat SHALL be the next set bit, and lanes SHALL be issued in ascending order.
REQ-024 A beat SHALL complete on a rising edge where memWe=1 and memReady=1; bit k is then cleared from the remaining mask.
REQ-025 While memReady=0, memWe, memAddr and memData SHALL hold stable.
REQ-026 On completion of the last remaining beat, SHALL go to DONE.
REQ-027 In DONE, SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-028 SHALL drive memWe=0 in IDLE and DONE; memAddr and memData are don't-care when memWe=0.
REQ-029 SHALL assert stall=1 in WRITE and DONE and stall=0 in IDLE, from registered state only.
REQ-030 SHALL ignore start outside IDLE; the captured request SHALL be unaffected by input changes after capture.
REQ-031 Latency, all-ready case: start at edge 0 -> first beat in cycle 1, n beats in cycles 1..n, done in cycle n+1, IDLE in cycle n+2.
REQ-032 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH with no error indication.

Reset
REQ-033 With rst_n=0 at a rising edge, SHALL enter IDLE, clear the remaining mask, and drive memWe=0, stall=0 and done=0 from that edge; this overrides all other inputs.
REQ-034 Reset during WRITE SHALL abort the store: no further beats and no done pulse.

Verification
REQ-035 Bench SHALL cover: vector store, base 0x100, mask 6'b111111, data 0x060504030201, memReady=1 -> six beats at 0x100..0x105 with data 01..06, done in cycle 7.
REQ-036 Bench SHALL cover: mask 6'b100101, base 0x20 -> exactly three beats at 0x20, 0x22, 0x25, done in cycle 4.
REQ-037 Bench SHALL cover: writeScalar=1, laneMask 6'b000000, data 0x...AB -> one beat at baseAddr with data 0xAB, done in cycle 2.
REQ-038 Bench SHALL cover: vector store with mask 0 -> no memWe, done in cycle 1, stall high for one cycle.
REQ-039 Bench SHALL cover: memReady low for 3 cycles on beat 2 -> memAddr and memData held, done delayed by 3 cycles, and start pulses in WRITE ignored.
REQ-040 Bench SHALL cover: base 0xFFFFFFFE, full mask -> addresses FFFFFFFE, FFFFFFFF, 0, 1, 2, 3; also rst_n=0 during beat 3 -> memWe=0 next cycle, no done.

Source files
------------

// File: rtl/vector_store_sequencer.sv
// Vector store sequencer: serialises a packed multi-lane store word into one
// memory beat per enabled lane, in ascending lane order, with ready back-pressure.
module vector_store_sequencer #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned LANES      = 6,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  writeScalar,
  input  logic [LANES-1:0]      laneMask,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [DATA_WIDTH-1:0] dataToWrite,
  input  logic                  memReady,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [LANE_WIDTH-1:0] memData,
  output logic                  stall,
  output logic                  done
);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } stateE;

  stateE                 stateQ, stateD;
  logic [LANES-1:0]      maskQ, maskD;
  logic [ADDR_WIDTH-1:0] baseQ, baseD;
  logic [DATA_WIDTH-1:0] dataQ, dataD;

  logic [LANES-1:0]      effMask;
  logic [LANES-1:0]      laneBit;
  logic [LANES-1:0]      probe;
  logic [ADDR_WIDTH-1:0] laneOffset;
  logic [LANE_WIDTH-1:0] laneData;

  assign effMask = writeScalar ? LANES'(1) : laneMask;

  // Lowest set bit of the remaining mask wins: scan high to low, last hit sticks.
  always_comb begin
    laneBit    = '0;
    probe      = '0;
    laneOffset = '0;
    laneData   = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      probe = LANES'(1) << i;
      if ((maskQ & probe) != '0) begin
        laneBit    = probe;
        laneOffset = ADDR_WIDTH'(i);
        laneData   = LANE_WIDTH'(dataQ >> (i * LANE_WIDTH));
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    maskD  = maskQ;
    baseD  = baseQ;
    dataD  = dataQ;
    case (stateQ)
      StIdle: begin
        if (start) begin
          maskD  = effMask;
          baseD  = baseAddr;
          dataD  = dataToWrite;
          stateD = (effMask != '0) ? StWrite : StDone;
        end
      end
      StWrite: begin
        if (memReady) begin
          maskD = maskQ & ~laneBit;
          if ((maskQ & ~laneBit) == '0) begin
            stateD = StDone;
          end
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      maskQ  <= '0;
      baseQ  <= '0;
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      maskQ  <= maskD;
      baseQ  <= baseD;
      dataQ  <= dataD;
    end
  end

  assign memWe   = (stateQ == StWrite);
  assign memAddr = baseQ + laneOffset;
  assign memData = laneData;
  assign stall   = (stateQ != StIdle);
  assign done    = (stateQ == StDone);

endmodule

// File: tb/tb_vector_store_sequencer.sv
// Scoreboard bench for vector_store_sequencer: expected beats are queued when a
// store is launched and popped as the DUT issues accepted beats.
module tb_vector_store_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        writeScalar;
  logic [5:0]  laneMask;
  logic [31:0] baseAddr;
  logic [47:0] dataToWrite;
  logic        memReady;
  logic        memWe;
  logic [31:0] memAddr;
  logic [7:0]  memData;
  logic        stall;
  logic        done;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } beatT;

  beatT        expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          beatCount  = 0;
  logic        holdPend   = 1'b0;
  logic [31:0] holdAddr;
  logic [7:0]  holdData;

  always #5 clk = ~clk;

  vector_store_sequencer #(
    .DATA_WIDTH(48),
    .LANE_WIDTH(8),
    .LANES     (6),
    .ADDR_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .writeScalar(writeScalar),
    .laneMask   (laneMask),
    .baseAddr   (baseAddr),
    .dataToWrite(dataToWrite),
    .memReady   (memReady),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memData    (memData),
    .stall      (stall),
    .done       (done)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat monitor: every issued beat must match the scoreboard head and hold while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (memWe) begin
        if (holdPend) begin
          checkEq("holdAddr", memAddr, holdAddr);
          checkEq("holdData", memData, holdData);
        end
        if (expQ.size() == 0) begin
          checkEq("unexpectedBeat", memWe, 0);
        end else begin
          checkEq("beatAddr", memAddr, expQ[0].addr);
          checkEq("beatData", memData, expQ[0].data);
        end
        if (memReady) begin
          if (expQ.size() != 0) void'(expQ.pop_front());
          beatCount++;
          holdPend = 1'b0;
        end else begin
          holdPend = 1'b1;
          holdAddr = memAddr;
          holdData = memData;
        end
      end else begin
        holdPend = 1'b0;
      end
    end
  end

  task automatic scramble();
    writeScalar = 1'($urandom);
    laneMask    = 6'($urandom);
    baseAddr    = $urandom;
    dataToWrite = {16'($urandom), $urandom};
  endtask

  function automatic logic readyFor(input int cyc, input int holdFrom);
    return !(holdFrom != 0 && cyc >= holdFrom && cyc < holdFrom + 3);
  endfunction

  task automatic runTest(input string tag, input logic scalar, input logic [5:0] mask,
                         input logic [31:0] base, input logic [47:0] data,
                         input int holdFrom, input int expDone);
    logic [5:0] eff;
    int         b0;
    int         cyc;
    logic       fin;
    @(posedge clk); #1;
    eff = scalar ? 6'b000001 : mask;
    for (int i = 0; i < 6; i++) begin
      if (eff[i]) expQ.push_back('{addr: base + 32'(i), data: data[i*8 +: 8]});
    end
    b0          = beatCount;
    start       = 1'b1;
    writeScalar = scalar;
    laneMask    = mask;
    baseAddr    = base;
    dataToWrite = data;
    memReady    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    cyc      = 1;
    memReady = readyFor(cyc, holdFrom);
    fin      = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (done || cyc >= 40) begin
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        memReady = readyFor(cyc, holdFrom);
        // Start pulses and input churn while stalled must not disturb the store.
        start = !memReady;
        if (!memReady) scramble();
      end
    end
    checkEq({tag, "DoneCycle"}, cyc, expDone);
    checkEq({tag, "StallAtDone"}, stall, 1);
    checkEq({tag, "Beats"}, beatCount - b0, $countones(eff));
    @(negedge clk);
    checkEq({tag, "IdleStall"}, stall, 0);
    checkEq({tag, "IdleDone"}, done, 0);
    checkEq({tag, "IdleWe"}, memWe, 0);
    checkEq({tag, "QueueEmpty"}, expQ.size(), 0);
  endtask

  initial begin
    int   b0;
    logic sawDone;
    rst_n       = 1'b0;
    start       = 1'b0;
    writeScalar = 1'b0;
    laneMask    = '0;
    baseAddr    = '0;
    dataToWrite = '0;
    memReady    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("rstWe", memWe, 0);
    checkEq("rstStall", stall, 0);
    checkEq("rstDone", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    runTest("full",       1'b0, 6'b111111, 32'h0000_0100, 48'h060504030201, 0, 7);
    runTest("sparse",     1'b0, 6'b100101, 32'h0000_0020, 48'h665544332211, 0, 4);
    runTest("scalar",     1'b1, 6'b000000, 32'h0000_0040, 48'h5A5A5A5A5AAB, 0, 2);
    runTest("empty",      1'b0, 6'b000000, 32'h0000_0080, 48'h123456789ABC, 0, 1);
    runTest("stallBeat2", 1'b0, 6'b111111, 32'h0000_0200, 48'hF6F5F4F3F2F1, 2, 10);
    runTest("wrap",       1'b0, 6'b111111, 32'hFFFF_FFFE, 48'h0D0C0B0A0908, 0, 7);

    // Reset asserted during beat 3 of a wrapping full-mask store.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) expQ.push_back('{addr: 32'hFFFF_FFFE + 32'(i), data: 8'hC0 + 8'(i)});
    b0          = beatCount;
    start       = 1'b1;
    writeScalar = 1'b0;
    laneMask    = 6'b111111;
    baseAddr    = 32'hFFFF_FFFE;
    dataToWrite = 48'hC5C4C3C2C1C0;
    memReady    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkEq("abortWe", memWe, 0);
    checkEq("abortStall", stall, 0);
    checkEq("abortDone", done, 0);
    sawDone = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || memWe) sawDone = 1'b1;
    end
    checkEq("abortQuiet", sawDone, 0);
    checkEq("abortBeats", beatCount - b0, 3);
    checkEq("abortQueue", expQ.size(), 0);

    runTest("recover",    1'b0, 6'b011010, 32'h0000_1000, 48'hAABBCCDDEEFF, 0, 4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
